// File: rtl/x_pulse_gen.sv
// x_pulse_gen: on start, emits a programmed burst of single-cycle x pulses separated by
// programmable low gaps, then strobes done. `X_PULSE_GEN_MARK_EN adds o_mark (every 4th pulse).
module x_pulse_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_n_pulses,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_hold,
  input  logic             i_abort,
  output logic             o_x,
  output logic             o_busy,
  output logic             o_done,
`ifdef X_PULSE_GEN_MARK_EN
  output logic             o_mark,
`endif
  output logic [CNT_W-1:0] o_sent
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_n;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gcnt;
  logic [CNT_W-1:0] r_sent;
  logic             r_x;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_d;
  logic [CNT_W-1:0] w_n_d;
  logic [GAP_W-1:0] w_gap_d;
  logic [GAP_W-1:0] w_gcnt_d;
  logic [CNT_W-1:0] w_sent_d;

  // r_sent already counts the pulse being driven, so entering PULSE increments it.
  always_comb begin
    w_state_d = r_state;
    w_n_d     = r_n;
    w_gap_d   = r_gap;
    w_gcnt_d  = r_gcnt;
    w_sent_d  = r_sent;
    unique case (r_state)
      StIdle: begin
        if (i_start && !i_abort) begin
          w_n_d    = i_n_pulses;
          w_gap_d  = i_gap;
          w_sent_d = '0;
          if (i_n_pulses != '0) begin
            w_state_d = StPulse;
            w_sent_d  = CNT_W'(1);
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StPulse: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (r_sent == r_n) begin
          w_state_d = StDone;
        end else if (r_gap == '0) begin
          w_state_d = StPulse;
          w_sent_d  = r_sent + CNT_W'(1);
        end else begin
          w_state_d = StGap;
          w_gcnt_d  = r_gap;
        end
      end
      StGap: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (!i_hold) begin
          if (r_gcnt == GAP_W'(1)) begin
            w_state_d = StPulse;
            w_sent_d  = r_sent + CNT_W'(1);
          end else begin
            w_gcnt_d = r_gcnt - GAP_W'(1);
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_sent  <= '0;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_n     <= w_n_d;
      r_gap   <= w_gap_d;
      r_gcnt  <= w_gcnt_d;
      r_sent  <= w_sent_d;
      r_x     <= (w_state_d == StPulse);
      r_busy  <= (w_state_d != StIdle);
      r_done  <= (w_state_d == StDone);
    end
  end

  assign o_x    = r_x;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sent = r_sent;

`ifdef X_PULSE_GEN_MARK_EN
  logic r_mark;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mark <= 1'b0;
    end else begin
      r_mark <= (w_state_d == StPulse) && (w_sent_d[1:0] == 2'b00);
    end
  end

  assign o_mark = r_mark;
`endif

endmodule

// File: tb/tb_x_pulse_gen.sv
// Randomized bench for x_pulse_gen: per-burst expected traces are built from pulse/gap
// arithmetic, then compared cycle by cycle. Define X_PULSE_GEN_MARK_EN to also check o_mark.
module tb_x_pulse_gen;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;
  localparam int          MAXC  = 2048;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [CNT_W-1:0] i_n_pulses;
  logic [GAP_W-1:0] i_gap;
  logic             i_hold;
  logic             i_abort;
  logic             o_x;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_sent;
`ifdef X_PULSE_GEN_MARK_EN
  logic             o_mark;
`endif

  x_pulse_gen #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) u_dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_n_pulses(i_n_pulses),
    .i_gap     (i_gap),
    .i_hold    (i_hold),
    .i_abort   (i_abort),
    .o_x       (o_x),
    .o_busy    (o_busy),
    .o_done    (o_done),
`ifdef X_PULSE_GEN_MARK_EN
    .o_mark    (o_mark),
`endif
    .o_sent    (o_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_sent;

  bit ex_x    [MAXC];
  bit ex_busy [MAXC];
  bit ex_done [MAXC];
  bit ex_mark [MAXC];
  int ex_sent [MAXC];
  bit hold_v  [MAXC];
  bit abort_v [MAXC];
  bit start_v [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // abort_at: -1 none, -2 random, 0 start+abort together, >0 abort in that cycle.
  // Cycles hlo..hhi have hold forced high on top of hold_pct random holding.
  task automatic run_seq(input int n, input int g, input int abort_at, input int hold_pct,
                         input int hlo, input int hhi);
    int t, rem, stop, a, len;
    for (int i = 0; i < MAXC; i++) begin
      ex_x[i]    = 1'b0;
      ex_busy[i] = 1'b0;
      ex_done[i] = 1'b0;
      ex_mark[i] = 1'b0;
      ex_sent[i] = prev_sent;
      abort_v[i] = 1'b0;
      start_v[i] = 1'b0;
      hold_v[i]  = (int'($urandom_range(99)) < hold_pct) || (i >= hlo && i <= hhi);
    end
    start_v[0] = 1'b1;
    if (abort_at == 0) begin
      abort_v[0] = 1'b1;
      stop       = 0;
    end else begin
      t = 1;
      for (int k = 1; k <= n; k++) begin
        ex_x[t]    = 1'b1;
        ex_busy[t] = 1'b1;
        ex_sent[t] = k;
        ex_mark[t] = (k % 4 == 0);
        t++;
        if (k < n) begin
          // Low time lasts until g un-held cycles have elapsed.
          rem = g;
          while (rem > 0) begin
            ex_busy[t] = 1'b1;
            ex_sent[t] = k;
            if (!hold_v[t]) rem--;
            t++;
          end
        end
      end
      ex_busy[t] = 1'b1;
      ex_done[t] = 1'b1;
      ex_sent[t] = n;
      stop       = t;
      for (int i = t + 1; i < MAXC; i++) ex_sent[i] = n;
      a = abort_at;
      if (abort_at == -2) a = ($urandom_range(1) == 1) ? int'($urandom_range(stop, 1)) : -1;
      if (a > 0) begin
        abort_v[a] = 1'b1;
        for (int i = a + 1; i < MAXC; i++) begin
          ex_x[i]    = 1'b0;
          ex_busy[i] = 1'b0;
          ex_done[i] = 1'b0;
          ex_mark[i] = 1'b0;
          ex_sent[i] = ex_sent[a];
        end
        stop = a;
      end
      // Starts while busy must be ignored.
      for (int i = 1; i <= stop; i++) start_v[i] = ($urandom_range(2) == 0);
    end
    len = stop + 3;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      i_start    = start_v[i];
      i_abort    = abort_v[i];
      i_hold     = hold_v[i];
      i_n_pulses = (i == 0) ? CNT_W'(n) : CNT_W'($urandom);
      i_gap      = (i == 0) ? GAP_W'(g) : GAP_W'($urandom);
      check_eq("x", {31'd0, o_x}, {31'd0, ex_x[i]});
      check_eq("busy", {31'd0, o_busy}, {31'd0, ex_busy[i]});
      check_eq("done", {31'd0, o_done}, {31'd0, ex_done[i]});
      check_eq("sent", {24'd0, o_sent}, ex_sent[i]);
`ifdef X_PULSE_GEN_MARK_EN
      check_eq("mark", {31'd0, o_mark}, {31'd0, ex_mark[i]});
`endif
    end
    prev_sent = ex_sent[len - 1];
    i_start   = 1'b0;
    i_abort   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_x"}, {31'd0, o_x}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, o_done}, 32'd0);
    check_eq({tag, "_sent"}, {24'd0, o_sent}, 32'd0);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_start    = 1'b1;
    i_n_pulses = CNT_W'(3);
    i_gap      = GAP_W'(1);
    i_hold     = 1'b0;
    i_abort    = 1'b0;
    prev_sent  = 0;

    // Reset dominates a held start.
    @(posedge clk); #1;
    check_idle("rst1");
    @(posedge clk); #1;
    check_idle("rst2");
    i_rst   = 1'b0;
    i_start = 1'b0;
    @(posedge clk); #1;
    check_idle("post_rst");

    run_seq(3, 2, -1, 0, 1, 0);
    run_seq(4, 0, -1, 0, 1, 0);
    run_seq(0, 3, -1, 0, 1, 0);
    run_seq(5, 3, -1, 0, 6, 9);
    run_seq(6, 1, 3, 0, 1, 0);
    run_seq(2, 1, 0, 0, 1, 0);
    run_seq(255, 0, -1, 0, 1, 0);
    run_seq(1, 15, -1, 0, 1, 0);

    for (int s = 0; s < 40; s++) begin
      run_seq(int'($urandom_range(12)), int'($urandom_range(5)), -2, 25, 1, 0);
    end

    // Reset in the middle of a burst clears everything.
    @(posedge clk); #1;
    i_start    = 1'b1;
    i_n_pulses = CNT_W'(4);
    i_gap      = GAP_W'(1);
    @(posedge clk); #1;
    i_start = 1'b0;
    check_eq("mid_x", {31'd0, o_x}, 32'd1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check_idle("mid_rst");
    prev_sent = 0;
    run_seq(2, 2, -1, 20, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
